// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
//
// Responder side of the processor instruction-fetch handshake. The module holds
// a word-addressed instruction store that can be loaded synchronously. It
// answers each fetch request after a programmable number of wait states.
//
// Ports
//   clock            in   1           single clock, rising edge
//   reset            in   1           synchronous, active-high
//   InstMem_Read     in   1           fetch request, held high until Ack
//   InstMem_Address  in   30          word address of requested instruction
//   InstMem_In       out  32          instruction word, valid only with Ack
//   InstMem_Ack      out  1           one-cycle completion pulse
//   InstMem_Fault    out  1           pulses with Ack for an out-of-range fetch
//   Load_En          in   1           program-load write strobe
//   Load_Addr        in   ADDR_WIDTH  store index (relative to BASE_WORD)
//   Load_Data        in   32          word to write
//   Fetch_Count      out  16          Acks since reset, saturating at 16'hFFFF
//
// ADDR_WIDTH must stay below 30 so that the store depth fits the address
// space. LATENCY is legal over 0..15.
// -----------------------------------------------------------------------------
module inst_mem_responder #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter logic [29:0] BASE_WORD    = 30'h400,
  parameter int unsigned LATENCY      = 2,
  parameter logic [31:0] DEFAULT_INST = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  InstMem_Read,
  input  logic [29:0]           InstMem_Address,
  output logic [31:0]           InstMem_In,
  output logic                  InstMem_Ack,
  output logic                  InstMem_Fault,
  input  logic                  Load_En,
  input  logic [ADDR_WIDTH-1:0] Load_Addr,
  input  logic [31:0]           Load_Data,
  output logic [15:0]           Fetch_Count
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  // Wait counter start value. It is only used when LATENCY > 0.
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [29:0] addr_reg, addr_next;
  logic        ack_entry;

  logic [31:0] store [0:DEPTH-1];

  // Read address for the store. With LATENCY=0 the ACK-entry edge is the same
  // edge that samples the request, so the live bus is used while in IDLE.
  // In every other case the latched address is served.
  logic [29:0]           rd_word;
  logic [29:0]           rd_off;
  logic                  rd_oor;
  logic [ADDR_WIDTH-1:0] rd_idx;

  assign rd_word = (state_reg == IDLE) ? InstMem_Address : addr_reg;
  assign rd_off  = rd_word - BASE_WORD;
  // Addresses below BASE_WORD wrap to large offsets in 30 bits. They are
  // rejected explicitly so that a wrap-around is never taken as in-range.
  assign rd_oor  = (rd_word < BASE_WORD) || (rd_off >= DEPTH_W);
  assign rd_idx  = rd_off[ADDR_WIDTH-1:0];

  // Program-load port. This write is independent of the FSM and of reset.
  always_ff @(posedge clock) begin
    if (Load_En) begin
      store[Load_Addr] <= Load_Data;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    ack_entry  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (InstMem_Read) begin
          addr_next = InstMem_Address;
          if (LATENCY == 0) begin
            state_next = ACK;
            ack_entry  = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!InstMem_Read) begin
          state_next = IDLE;            // request withdrawn: no Ack
        end else if (cnt_reg == 4'd0) begin
          state_next = ACK;
          ack_entry  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ACK: begin
        // The request line is not sampled here. The processor still shows the
        // old address during this cycle.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= 30'd0;
      InstMem_In    <= 32'd0;
      InstMem_Ack   <= 1'b0;
      InstMem_Fault <= 1'b0;
      Fetch_Count   <= 16'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      InstMem_Ack <= ack_entry;
      if (ack_entry) begin
        // A load to the same index on this edge is not seen here. The read
        // samples the old word.
        InstMem_In    <= rd_oor ? DEFAULT_INST : store[rd_idx];
        InstMem_Fault <= rd_oor;
        if (Fetch_Count != 16'hFFFF) begin
          Fetch_Count <= Fetch_Count + 16'd1;
        end
      end else begin
        InstMem_In    <= 32'd0;
        InstMem_Fault <= 1'b0;
      end
    end
  end

endmodule
